// File: rtl/pe_pkg.sv
// Shared types and helpers for the vector MAC processing element.
//   DATA_WIDTH_DEF / ACC_WIDTH_DEF : default element and accumulator widths
//   acc_t                          : default-width signed accumulator type
//   wide_t                         : wide signed scratch type used by sat_add
//   lane_lsb()                     : LSB position of a lane in a packed lane vector
//   sat_add()                      : add, then wrap or clamp to a signed width
package pe_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned ACC_WIDTH_DEF  = 40;
   localparam int unsigned WIDE_W         = 64;

   typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;
   typedef logic signed [WIDE_W-1:0]        wide_t;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

   // Operands are sign-extended values of a signed 'width'-bit quantity; the
   // result is sign-extended back into wide_t after wrap or clamp.
   function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                     input int unsigned width, input logic saturate);
      wide_t s;
      wide_t hi;
      wide_t lo;
      s  = a + b;
      hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (saturate) begin
         if (s > hi)      s = hi;
         else if (s < lo) s = lo;
      end else begin
         s = (s <<< (WIDE_W - width)) >>> (WIDE_W - width);
      end
      return s;
   endfunction

endpackage

// File: rtl/pe_mult_pipe.sv
// LANES signed multipliers behind an operand register, followed by MULT_LAT
// product stages. Each stage carries valid, last and psum-enable tags.
//   en            : advance the whole pipe (low = freeze)
//   in_*          : accepted beat and its tags
//   out_*         : products and tags at the accumulate stage
//   any_valid     : any stage holds a beat
module pe_mult_pipe
   import pe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LANES      = 3,
   parameter int unsigned MULT_LAT   = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            in_valid,
   input  logic                            in_last,
   input  logic                            in_pen,
   input  logic [LANES*DATA_WIDTH-1:0]     ifmap,
   input  logic [LANES*DATA_WIDTH-1:0]     fltr,
   output logic                            out_valid,
   output logic                            out_last,
   output logic                            out_pen,
   output logic [LANES*2*DATA_WIDTH-1:0]   out_prod,
   output logic                            any_valid
);

   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam int unsigned OPW = LANES * DATA_WIDTH;
   localparam int unsigned PRW = LANES * PW;

   logic [OPW-1:0]      a_q, a_d, b_q, b_d;
   logic                v0_q, v0_d, l0_q, l0_d, p0_q, p0_d;
   logic [PRW-1:0]      prod_c;
   logic [PRW-1:0]      prod_q [MULT_LAT];
   logic [PRW-1:0]      prod_d [MULT_LAT];
   logic [MULT_LAT-1:0] vld_q, vld_d, last_q, last_d, pen_q, pen_d;

   // Operand capture: data only loads on an accepted beat.
   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      v0_d = v0_q;
      l0_d = l0_q;
      p0_d = p0_q;
      if (en) begin
         v0_d = in_valid;
         if (in_valid) begin
            a_d  = ifmap;
            b_d  = fltr;
            l0_d = in_last;
            p0_d = in_pen;
         end
      end
   end

   // Signed lane products.
   always_comb begin
      prod_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         prod_c[lane_lsb(i, PW) +: PW] =
            PW'($signed(a_q[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])) *
            PW'($signed(b_q[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]));
      end
   end

   // Product shift chain.
   always_comb begin
      for (int unsigned s = 0; s < MULT_LAT; s++) prod_d[s] = prod_q[s];
      vld_d  = vld_q;
      last_d = last_q;
      pen_d  = pen_q;
      if (en) begin
         prod_d[0] = prod_c;
         vld_d[0]  = v0_q;
         last_d[0] = l0_q;
         pen_d[0]  = p0_q;
         for (int unsigned s = 1; s < MULT_LAT; s++) begin
            prod_d[s] = prod_q[s-1];
            vld_d[s]  = vld_q[s-1];
            last_d[s] = last_q[s-1];
            pen_d[s]  = pen_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         v0_q   <= 1'b0;
         l0_q   <= 1'b0;
         p0_q   <= 1'b0;
         vld_q  <= '0;
         last_q <= '0;
         pen_q  <= '0;
         for (int unsigned s = 0; s < MULT_LAT; s++) prod_q[s] <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         v0_q   <= v0_d;
         l0_q   <= l0_d;
         p0_q   <= p0_d;
         vld_q  <= vld_d;
         last_q <= last_d;
         pen_q  <= pen_d;
         for (int unsigned s = 0; s < MULT_LAT; s++) prod_q[s] <= prod_d[s];
      end
   end

   assign out_valid = vld_q[MULT_LAT-1];
   assign out_last  = last_q[MULT_LAT-1];
   assign out_pen   = pen_q[MULT_LAT-1];
   assign out_prod  = prod_q[MULT_LAT-1];
   assign any_valid = v0_q | (|vld_q);

endmodule

// File: rtl/sv_pe_vmac.sv
// Vector multiply-accumulate PE: LANES products per beat, summed across lanes
// and accumulated over cfg_len beats, optionally plus an upstream partial sum.
//   cfg_len / cfg_psum_en       : group length (0 = 1) and psum add, latched per group
//   in_valid/in_ready, ifmap/fltr : beat handshake and packed signed lanes
//   psum_in*                    : upstream partial sum, consumed on a group's last beat
//   out_valid/out_ready/out_psum : registered group result
//   busy                        : beat in flight or group partially accumulated
module sv_pe_vmac
   import pe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LANES      = 3,
   parameter int unsigned MULT_LAT   = 2,
   parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned SATURATE   = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CNT_WIDTH-1:0]        cfg_len,
   input  logic                        cfg_psum_en,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] ifmap,
   input  logic [LANES*DATA_WIDTH-1:0] fltr,
   input  logic                        psum_in_valid,
   output logic                        psum_in_ready,
   input  logic [ACC_WIDTH-1:0]        psum_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_WIDTH-1:0]        out_psum,
   output logic                        busy
);

   localparam int unsigned PW  = 2 * DATA_WIDTH;
   localparam int unsigned PRW = LANES * PW;

   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, len_q, len_d, len_eff;
   logic                        psum_en_q, psum_en_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0]        out_psum_q, out_psum_d;
   logic                        out_valid_q, out_valid_d;
   logic                        pipe_valid, pipe_last, pipe_pen, pipe_busy;
   logic [PRW-1:0]              pipe_prod;
   logic                        last_at_acc, stall, accept, beat_last, beat_pen;
   wide_t                       sum_w, part_w, res_w;

   // Only a last beat can stall: it needs a free output slot and, if enabled, psum_in.
   assign last_at_acc   = pipe_valid & pipe_last;
   assign stall         = last_at_acc & ((out_valid_q & ~out_ready) | (pipe_pen & ~psum_in_valid));
   assign in_ready      = ~stall & ~rst;
   assign accept        = in_valid & in_ready;
   assign psum_in_ready = last_at_acc & pipe_pen & ~stall;
   assign busy          = pipe_busy | (cnt_q != '0);
   assign out_valid     = out_valid_q;
   assign out_psum      = out_psum_q;

   // Beat counter; the first beat of a group uses live config, later beats the latched copy.
   always_comb begin
      cnt_d     = cnt_q;
      len_d     = len_q;
      psum_en_d = psum_en_q;
      len_eff   = len_q;
      beat_pen  = psum_en_q;
      if (cnt_q == '0) begin
         len_eff  = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
         beat_pen = cfg_psum_en;
      end
      beat_last = (cnt_q == len_eff - CNT_WIDTH'(1));
      if (accept) begin
         if (cnt_q == '0) begin
            len_d     = len_eff;
            psum_en_d = cfg_psum_en;
         end
         cnt_d = beat_last ? '0 : cnt_q + CNT_WIDTH'(1);
      end
   end

   // psum enable travels with each beat so a newly started group cannot retag a group in flight.
   pe_mult_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .MULT_LAT   (MULT_LAT)
   ) u_mult (
      .clk       (clk),
      .rst       (rst),
      .en        (~stall),
      .in_valid  (accept),
      .in_last   (beat_last),
      .in_pen    (beat_pen),
      .ifmap     (ifmap),
      .fltr      (fltr),
      .out_valid (pipe_valid),
      .out_last  (pipe_last),
      .out_pen   (pipe_pen),
      .out_prod  (pipe_prod),
      .any_valid (pipe_busy)
   );

   // Lane sum, accumulate and output register; the last beat clears acc on the result edge.
   always_comb begin
      sum_w = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         sum_w = sum_w + WIDE_W'($signed(pipe_prod[lane_lsb(i, PW) +: PW]));
      end
      part_w = sat_add(WIDE_W'(acc_q), sum_w, ACC_WIDTH, SATURATE != 0);
      res_w  = pipe_pen ? sat_add(part_w, WIDE_W'($signed(psum_in)), ACC_WIDTH, SATURATE != 0)
                        : part_w;
      acc_d       = acc_q;
      out_valid_d = out_valid_q & ~out_ready;
      out_psum_d  = out_psum_q;
      if (pipe_valid & ~stall) begin
         if (pipe_last) begin
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_psum_d  = ACC_WIDTH'(res_w);
         end else begin
            acc_d = ACC_WIDTH'(part_w);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         len_q       <= CNT_WIDTH'(1);
         psum_en_q   <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_psum_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         psum_en_q   <= psum_en_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_psum_q  <= out_psum_d;
      end
   end

endmodule
